// File: rtl/mc_main_controller.sv
// Multi-cycle datapath main controller: fetch/decode/execute/memory/writeback FSM
// with a bounded memory-wait watchdog. Optional retire counter under MC_RETIRE_COUNT_EN.
module mc_main_controller #(
    parameter int WAIT_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       notnoop,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       err
`ifdef MC_RETIRE_COUNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EX_R, WB_R, EX_I, WB_I, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, JUMP, BRZ, ERR
    } state_t;

    localparam logic [2:0] OP_R     = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_ANDI  = 3'b010;
    localparam logic [2:0] OP_ORI   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    opc_q, opc_d;
    logic          wait_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opc_d      = opc_q;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        err        = 1'b0;
        wait_st    = 1'b0;

        case (state_q)
            FETCH: begin
                wait_st   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                opc_d = opcode;
                case (opcode)
                    OP_R:                      state_d = EX_R;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = EX_I;
                    OP_LOAD, OP_STORE:         state_d = MEM_ADDR;
                    OP_JMP:                    state_d = JUMP;
                    default:                   state_d = BRZ;
                endcase
            end
            EX_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = WB_R;
            end
            WB_R: begin
                reg_write = notnoop;
                state_d   = FETCH;
            end
            EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opc_q)
                    OP_ANDI: alu_op = 3'b011;
                    OP_ORI:  alu_op = 3'b100;
                    default: alu_op = 3'b000;
                endcase
                state_d = WB_I;
            end
            WB_I: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opc_q == OP_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                wait_st  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                wait_st   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b01;
                state_d  = FETCH;
            end
            BRZ: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b10;
                pc_write  = zero;
                state_d   = FETCH;
            end
            default: begin
                err     = 1'b1;
                state_d = ERR;
            end
        endcase

        // Watchdog: a full count with the memory still stalled escalates to ERR.
        if (wait_st && !mem_ready) begin
            if (cnt_q == WAIT_LIM) state_d = ERR;
            else                   cnt_d   = cnt_q + CW'(1);
        end
        if (state_d != state_q &&
            (state_d == FETCH || state_d == MEM_RD || state_d == MEM_WR)) begin
            cnt_d = '0;
        end

        // Outputs are forced idle for the whole reset assertion, not only after the edge.
        if (!rst) begin
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 3'b000;
            err        = 1'b0;
        end
    end

`ifdef MC_RETIRE_COUNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (state_d == FETCH && state_q != FETCH && state_q != ERR) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retired_q <= '0;
        else      retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller; outputs packed into one vector and compared
// against hand-built patterns. Also exercises MC_RETIRE_COUNT_EN when defined.
module tb_mc_main_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero, notnoop, mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, mem_to_reg, alu_src_a, err;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
`ifdef MC_RETIRE_COUNT_EN
    logic [15:0] retired;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_main_controller #(.WAIT_MAX(15), .CW(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .notnoop(notnoop),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .err(err)
`ifdef MC_RETIRE_COUNT_EN
        , .retired(retired)
`endif
    );

    logic [15:0] outs;
    assign outs = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
                   reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, err};

    function automatic logic [15:0] pk(input logic pw, input logic [1:0] ps,
                                       input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic rw, input logic m2r,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic er);
        return {pw, ps, iod, mr, mw, irw, rw, m2r, asa, asb, aop, er};
    endfunction

    localparam logic [15:0] IDLE      = 16'h0000;
    logic [15:0] fetch_rdy, fetch_wait, ex_r, brz_t, brz_f, jmp_o, mem_addr;
    logic [15:0] mem_rd, mem_wb, mem_wr, wb, err_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input string tag, input logic [15:0] exp);
        #1;
        check(tag, {16'h0, outs}, {16'h0, exp});
    endtask

    logic [2:0] ei_ops [3];
    logic [2:0] ei_aop [3];

    initial begin
        fetch_rdy  = pk(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b01, 3'b000, 0);
        fetch_wait = pk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
        ex_r       = pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
        brz_t      = pk(1, 2'b10, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0);
        brz_f      = pk(0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0);
        jmp_o      = pk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
        mem_addr   = pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0);
        mem_rd     = pk(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
        mem_wb     = pk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0);
        mem_wr     = pk(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0);
        wb         = pk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 0);
        err_o      = pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);
        ei_ops = '{3'b001, 3'b010, 3'b011};
        ei_aop = '{3'b000, 3'b011, 3'b100};

        rst = 1'b0; opcode = 3'b000; zero = 1'b0; notnoop = 1'b1; mem_ready = 1'b1;
        step(); step();
        settle_check("reset_idle", IDLE);
`ifdef MC_RETIRE_COUNT_EN
        check("reset_retired", {16'h0, retired}, 32'd0);
`endif
        rst = 1'b1;
        settle_check("fetch_after_reset", fetch_rdy);

        // R-type, notnoop=1
        step(); settle_check("r_decode", IDLE);
        step(); settle_check("r_ex", ex_r);
        step(); settle_check("r_wb", wb);
        step(); settle_check("r_back_fetch", fetch_rdy);

        // R-type Nop
        step(); step(); step();
        notnoop = 1'b0;
        settle_check("rnop_wb", IDLE);
        notnoop = 1'b1;
        step(); settle_check("rnop_fetch", fetch_rdy);

        // Immediate ops; opcode changed after DECODE to prove it was captured
        for (int i = 0; i < 3; i++) begin
            opcode = ei_ops[i];
            step(); settle_check("imm_decode", IDLE);
            step(); opcode = 3'b110;
            settle_check($sformatf("imm_ex_%0d", i),
                         pk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, ei_aop[i], 0));
            step(); settle_check("imm_wb", wb);
            step(); settle_check("imm_fetch", fetch_rdy);
        end

        // LOAD with three stalled cycles in MEM_RD
        opcode = 3'b100;
        step(); step(); settle_check("ld_addr", mem_addr);
        step(); mem_ready = 1'b0;
        settle_check("ld_rd_w0", mem_rd);
        step(); settle_check("ld_rd_w1", mem_rd);
        step(); settle_check("ld_rd_w2", mem_rd);
        step(); mem_ready = 1'b1;
        settle_check("ld_rd_done", mem_rd);
        step(); settle_check("ld_wb", mem_wb);
        step(); settle_check("ld_fetch", fetch_rdy);

        // STORE
        opcode = 3'b101;
        step(); step(); settle_check("st_addr", mem_addr);
        step(); settle_check("st_wr", mem_wr);
        step(); settle_check("st_fetch", fetch_rdy);

        // JZ taken then not taken
        opcode = 3'b111; zero = 1'b1;
        step(); step(); settle_check("jz_taken", brz_t);
        step(); settle_check("jz1_fetch", fetch_rdy);
        zero = 1'b0;
        step(); step(); settle_check("jz_not_taken", brz_f);
        step(); settle_check("jz2_fetch", fetch_rdy);

        // JMP
        opcode = 3'b110;
        step(); step(); settle_check("jmp", jmp_o);
        step(); settle_check("jmp_fetch", fetch_rdy);
`ifdef MC_RETIRE_COUNT_EN
        check("retired_count", {16'h0, retired}, 32'd10);
`endif

        // STORE stalled exactly WAIT_MAX cycles, then completes without error
        opcode = 3'b101;
        step(); step(); step();
        mem_ready = 1'b0;
        settle_check("st_stall_start", mem_wr);
        repeat (15) step();
        settle_check("st_stall_limit", mem_wr);
        mem_ready = 1'b1;
        #1 check("st_limit_no_err", {31'h0, err}, 32'd0);
        step(); settle_check("st_limit_fetch", fetch_rdy);

        // FETCH timeout
        mem_ready = 1'b0;
        settle_check("fetch_wait", fetch_wait);
        repeat (15) step();
        settle_check("fetch_wait_15", fetch_wait);
        step(); settle_check("fetch_timeout_err", err_o);
        mem_ready = 1'b1;
        step(); step(); settle_check("err_sticky", err_o);
        rst = 1'b0;
        settle_check("err_cleared_by_rst", IDLE);
        step();
        rst = 1'b1;
        settle_check("post_err_fetch", fetch_rdy);

        // Asynchronous reset during MEM_WR
        opcode = 3'b101;
        step(); step(); step();
        mem_ready = 1'b0;
        settle_check("rst_mid_wr", mem_wr);
        #2 rst = 1'b0;
        settle_check("rst_mid_drop", IDLE);
`ifdef MC_RETIRE_COUNT_EN
        check("rst_mid_retired", {16'h0, retired}, 32'd0);
`endif
        step();
        rst = 1'b1; mem_ready = 1'b1;
        settle_check("rst_mid_fetch", fetch_rdy);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
